// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: state encodings, widths and the PC increment.
package mips_pkg;
   localparam int          INST_W       = 32;
   localparam logic [31:0] PC_INC       = 32'd4;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      F_IDLE = 2'd0,
      F_REQ  = 2'd1,
      F_DROP = 2'd2
   } fetch_state_t;

   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + PC_INC;
   endfunction
endpackage

// File: rtl/fetch_skid_buf.sv
// Output slot plus one-entry skid for the IF stage; data word is {inst, pc+4}.
module fetch_skid_buf
   import mips_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [2*INST_W-1:0]   in_data,
   input  logic                  consume,
   input  logic                  clear,
   output logic                  out_valid,
   output logic [2*INST_W-1:0]   out_data,
   output logic                  skid_full
);
   logic                r_slot_v;
   logic                r_skid_v;
   logic [2*INST_W-1:0] r_slot;
   logic [2*INST_W-1:0] r_skid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot_v <= 1'b0;
         r_skid_v <= 1'b0;
         r_slot   <= '0;
         r_skid   <= '0;
      end else if (clear) begin
         r_slot_v <= 1'b0;
         r_skid_v <= 1'b0;
      end else if (in_valid) begin
         // the skid is never full when new data arrives: no request is issued then
         if (!r_slot_v || consume) begin
            r_slot_v <= 1'b1;
            r_slot   <= in_data;
         end else begin
            r_skid_v <= 1'b1;
            r_skid   <= in_data;
         end
      end else if (consume) begin
         r_slot_v <= r_skid_v;
         if (r_skid_v)
            r_slot <= r_skid;
         r_skid_v <= 1'b0;
      end
   end

   assign out_valid = r_slot_v;
   assign out_data  = r_slot;
   assign skid_full = r_skid_v;
endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage producer: owns the PC, fetches over imem req/ack, feeds IF/ID via a slot+skid.
//   state  | meaning
//   F_IDLE | no request outstanding; skid full, waiting for IF/ID to drain
//   F_REQ  | request outstanding at pc; returned data is kept
//   F_DROP | request outstanding at the pre-redirect address; returned data is discarded
module if_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              Stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic              imem_req,
   output logic [31:0]       imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   output logic [INST_W-1:0] IF_inst_in,
   output logic [31:0]       IF_PC_Plus_4,
   output logic              inst_en
);
   fetch_state_t          r_state;
   logic [31:0]           r_pc;
   logic [31:0]           r_drop_addr;
   logic                  w_consume;
   logic                  w_keep;
   logic                  w_out_valid;
   logic                  w_skid_full;
   logic [2*INST_W-1:0]   w_out_data;

   assign w_consume = w_out_valid & ~Stall;
   assign w_keep    = (r_state == F_REQ) & imem_ack & ~redirect;

   fetch_skid_buf u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (w_keep),
      .in_data   ({imem_rdata, pc_next(r_pc)}),
      .consume   (w_consume),
      .clear     (redirect),
      .out_valid (w_out_valid),
      .out_data  (w_out_data),
      .skid_full (w_skid_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= F_REQ;
         r_pc        <= RESET_PC;
         r_drop_addr <= RESET_PC;
      end else if (redirect) begin
         r_pc <= redirect_pc;
         // an unacked request must keep its address until memory answers
         if (r_state != F_IDLE && !imem_ack) begin
            r_state <= F_DROP;
            if (r_state == F_REQ)
               r_drop_addr <= r_pc;
         end else begin
            r_state <= F_REQ;
         end
      end else begin
         case (r_state)
            F_REQ: begin
               if (imem_ack) begin
                  r_pc <= pc_next(r_pc);
                  if (w_out_valid && !w_consume)
                     r_state <= F_IDLE;
               end
            end
            F_DROP: begin
               if (imem_ack)
                  r_state <= F_REQ;
            end
            F_IDLE: begin
               if (w_consume || !w_skid_full)
                  r_state <= F_REQ;
            end
            default: r_state <= F_REQ;
         endcase
      end
   end

   assign imem_req     = (r_state == F_REQ || r_state == F_DROP) && !rst;
   assign imem_addr    = (r_state == F_DROP) ? r_drop_addr : r_pc;
   assign IF_inst_in   = w_out_data[2*INST_W-1:INST_W];
   assign IF_PC_Plus_4 = w_out_data[31:0];
   assign inst_en      = w_out_valid;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a queue-based model of the fetch stream.
module tb_if_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h100;

   logic        clk = 1'b0;
   logic        rst, Stall, redirect, imem_ack, imem_req, inst_en;
   logic [31:0] redirect_pc, imem_addr, imem_rdata, IF_inst_in, IF_PC_Plus_4;

   always #5 clk = ~clk;

   if_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .Stall        (Stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .IF_inst_in   (IF_inst_in),
      .IF_PC_Plus_4 (IF_PC_Plus_4),
      .inst_en      (inst_en)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   // Model: fetched-but-unconsumed instructions in order, plus the one outstanding fetch.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } beat_t;

   beat_t       q[$];
   logic        m_out_v    = 1'b0;
   logic        m_out_drop = 1'b0;
   logic [31:0] m_out_addr = '0;
   logic [31:0] m_pc       = '0;
   logic        m_zero     = 1'b0;
   int          mem_wait   = 0;
   int          lat_min    = 0;
   int          lat_max    = 0;
   int          stall_pct  = 0;
   int          redir_pct  = 0;
   int          stall_run  = 0;
   int          n_beats    = 0;

   task automatic new_fetch(input logic [31:0] a);
      m_out_v    = 1'b1;
      m_out_addr = a;
      m_out_drop = 1'b0;
      mem_wait   = int'($urandom_range(lat_max, lat_min));
   endtask

   task automatic model_edge();
      bit consume;
      if (rst) begin
         q.delete();
         m_pc   = RST_PC;
         m_zero = 1'b1;
         new_fetch(RST_PC);
         return;
      end
      consume = (q.size() > 0) && !Stall;
      if (consume) n_beats++;
      if (redirect) begin
         q.delete();
         m_pc = redirect_pc;
         if (m_out_v && !imem_ack) m_out_drop = 1'b1;
         else                      new_fetch(redirect_pc);
         return;
      end
      if (consume) void'(q.pop_front());
      if (imem_ack && m_out_v) begin
         if (m_out_drop) begin
            new_fetch(m_pc);
         end else begin
            q.push_back('{pc: m_out_addr, data: imem_rdata});
            m_zero  = 1'b0;
            m_pc    = m_out_addr + 32'd4;
            m_out_v = 1'b0;
         end
      end
      if (!m_out_v && q.size() < 2) new_fetch(m_pc);
   endtask

   task automatic check_outputs();
      logic exp_req;
      exp_req = m_out_v && !rst;
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (m_out_v) chk("imem_addr", imem_addr, m_out_addr);
      chk("inst_en", 32'(inst_en), 32'(q.size() > 0));
      if (q.size() > 0) begin
         chk("pc_plus_4", IF_PC_Plus_4, q[0].pc + 32'd4);
         chk("inst_word", IF_inst_in, q[0].data);
      end else if (m_zero) begin
         chk("rst_pc_plus_4", IF_PC_Plus_4, 32'h0);
         chk("rst_inst_word", IF_inst_in, 32'h0);
      end
   endtask

   function automatic logic [31:0] pick_target();
      case ($urandom_range(3, 0))
         0:       return 32'h0000_0400;
         1:       return 32'hFFFF_FFFC;
         2:       return 32'hFFFF_FFF8;
         default: return $urandom & 32'hFFFF_FFFC;
      endcase
   endfunction

   initial begin
      rst = 1'b1; Stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_ack = 1'b0; imem_rdata = '0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         model_edge();
         cyc = c;
         #1;
         if (c < 200)      begin lat_min = 0; lat_max = 0; stall_pct = 0;  redir_pct = 0; end
         else if (c < 400) begin lat_min = 2; lat_max = 2; stall_pct = 0;  redir_pct = 0; end
         else if (c < 700) begin lat_min = 0; lat_max = 1; stall_pct = 60; redir_pct = 3; end
         else              begin lat_min = 0; lat_max = 3; stall_pct = 40; redir_pct = 8; end
         rst = (c < 3) || (c > 700 && $urandom_range(299, 0) == 0);
         #1;
         if (c >= 1) check_outputs();
         if (rst) begin
            Stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
         end else begin
            if (stall_run == 0) begin
               Stall     = ($urandom_range(99, 0) < stall_pct);
               stall_run = int'($urandom_range(4, 1));
            end
            stall_run--;
            redirect    = ($urandom_range(99, 0) < redir_pct);
            redirect_pc = pick_target();
            imem_ack    = 1'b0;
            if (m_out_v) begin
               if (mem_wait == 0) imem_ack = 1'b1;
               else               mem_wait--;
            end
            imem_rdata = imem_ack ? $urandom : 32'h0;
         end
      end
      chk("stream_progress", 32'(n_beats > 500), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
